// File: rtl/instr_decode_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode_if
// Description : Bundle of the decode-stage signals: fetched instruction and PCs
//               coming in, writeback port, decoded control and operands out.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_decode_if;
  // Fetch side
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic [31:0] next_pc_in;
  // Writeback side
  logic [31:0] reg_write_data;
  logic        reg_write_enable;
  logic [4:0]  reg_write_addr;
  // Execute side
  logic [31:0] pc_out;
  logic [31:0] next_pc_out;
  logic        rd_write_enable;
  logic [4:0]  rd_write_addr;
  logic        res_src;
  logic        branch;
  logic [5:0]  alu_op;
  logic        alu_input_conf;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  // Driver of the decode stage (fetch/writeback logic or a testbench)
  modport master (
    output instr, pc_in, next_pc_in,
    output reg_write_data, reg_write_enable, reg_write_addr,
    input  pc_out, next_pc_out, rd_write_enable, rd_write_addr, res_src,
    input  branch, alu_op, alu_input_conf, imm, rs1_data, rs2_data
  );

  // The decode stage itself
  modport slave (
    input  instr, pc_in, next_pc_in,
    input  reg_write_data, reg_write_enable, reg_write_addr,
    output pc_out, next_pc_out, rd_write_enable, rd_write_addr, res_src,
    output branch, alu_op, alu_input_conf, imm, rs1_data, rs2_data
  );
endinterface
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode
// Description : RV32I decode stage. Combinational instruction decode and
//               immediate generation, plus the 32x32 integer register file
//               with a same-cycle writeback bypass on both read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decode (
  input  logic          clk,
  input  logic          rst_n,
  instr_decode_if.slave bus
);

  // Major opcodes
  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;

  localparam logic [6:0] c_f7_base = 7'b0000000;
  localparam logic [6:0] c_f7_alt  = 7'b0100000;

  localparam logic [5:0] c_alu_illegal = 6'h3F;

  // Instruction fields
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;

  assign w_opcode = bus.instr[6:0];
  assign w_funct3 = bus.instr[14:12];
  assign w_funct7 = bus.instr[31:25];
  assign w_rd     = bus.instr[11:7];
  assign w_rs1    = bus.instr[19:15];
  assign w_rs2    = bus.instr[24:20];

  // Pre-formed immediates for every RV32I format
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_imm_i = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign w_imm_s = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign w_imm_b = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                    bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign w_imm_u = {bus.instr[31:12], 12'h000};
  assign w_imm_j = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                    bus.instr[20], bus.instr[30:21], 1'b0};

  // Register/immediate ALU operation from funct3; alt selects SUB/SRA
  function automatic logic [5:0] alu_rr(input logic [2:0] f3, input logic alt);
    logic [5:0] op;
    case (f3)
      3'd0:    op = alt ? 6'h01 : 6'h00;
      3'd1:    op = 6'h02;
      3'd2:    op = 6'h03;
      3'd3:    op = 6'h04;
      3'd4:    op = 6'h05;
      3'd5:    op = alt ? 6'h07 : 6'h06;
      3'd6:    op = 6'h08;
      default: op = 6'h09;
    endcase
    return op;
  endfunction

  logic        w_legal;
  logic        w_writes_rd;
  logic        w_res_src;
  logic        w_branch;
  logic        w_conf;
  logic [5:0]  w_alu_op;
  logic [31:0] w_imm;

  // Main decoder: classify the opcode, reject reserved encodings, pick fields
  always_comb begin
    w_legal     = 1'b0;
    w_writes_rd = 1'b0;
    w_res_src   = 1'b0;
    w_branch    = 1'b0;
    w_conf      = 1'b0;
    w_alu_op    = c_alu_illegal;
    w_imm       = '0;
    case (w_opcode)
      c_opc_op: begin
        // Only ADD/SUB and SRL/SRA have an alternate funct7
        w_legal     = (w_funct7 == c_f7_base) ||
                      ((w_funct7 == c_f7_alt) && (w_funct3 == 3'd0 || w_funct3 == 3'd5));
        w_writes_rd = 1'b1;
        w_alu_op    = alu_rr(w_funct3, bus.instr[30]);
      end
      c_opc_op_imm: begin
        // Shift-immediates carry funct7 in the upper imm bits; others take any imm
        if (w_funct3 == 3'd1)
          w_legal = (w_funct7 == c_f7_base);
        else if (w_funct3 == 3'd5)
          w_legal = (w_funct7 == c_f7_base) || (w_funct7 == c_f7_alt);
        else
          w_legal = 1'b1;
        w_writes_rd = 1'b1;
        w_conf      = 1'b1;
        // ADDI never becomes SUB, so the alternate bit only matters for SRAI
        w_alu_op    = alu_rr(w_funct3, (w_funct3 == 3'd5) && bus.instr[30]);
        w_imm       = w_imm_i;
      end
      c_opc_load: begin
        w_legal     = 1'b1;
        w_writes_rd = 1'b1;
        w_res_src   = 1'b1;
        w_conf      = 1'b1;
        w_imm       = w_imm_i;
        case (w_funct3)
          3'd0:    w_alu_op = 6'h28;
          3'd1:    w_alu_op = 6'h29;
          3'd2:    w_alu_op = 6'h2A;
          3'd4:    w_alu_op = 6'h2B;
          3'd5:    w_alu_op = 6'h2C;
          default: w_legal  = 1'b0;
        endcase
      end
      c_opc_store: begin
        w_legal  = (w_funct3 <= 3'd2);
        w_conf   = 1'b1;
        w_alu_op = 6'h30 + {3'b000, w_funct3};
        w_imm    = w_imm_s;
      end
      c_opc_branch: begin
        w_legal  = 1'b1;
        w_branch = 1'b1;
        w_imm    = w_imm_b;
        case (w_funct3)
          3'd0:    w_alu_op = 6'h10;
          3'd1:    w_alu_op = 6'h11;
          3'd4:    w_alu_op = 6'h12;
          3'd5:    w_alu_op = 6'h13;
          3'd6:    w_alu_op = 6'h14;
          3'd7:    w_alu_op = 6'h15;
          default: w_legal  = 1'b0;
        endcase
      end
      c_opc_lui: begin
        w_legal     = 1'b1;
        w_writes_rd = 1'b1;
        w_conf      = 1'b1;
        w_alu_op    = 6'h20;
        w_imm       = w_imm_u;
      end
      c_opc_auipc: begin
        w_legal     = 1'b1;
        w_writes_rd = 1'b1;
        w_conf      = 1'b1;
        w_alu_op    = 6'h21;
        w_imm       = w_imm_u;
      end
      c_opc_jal: begin
        w_legal     = 1'b1;
        w_writes_rd = 1'b1;
        w_branch    = 1'b1;
        w_conf      = 1'b1;
        w_alu_op    = 6'h22;
        w_imm       = w_imm_j;
      end
      c_opc_jalr: begin
        w_legal     = (w_funct3 == 3'd0);
        w_writes_rd = 1'b1;
        w_branch    = 1'b1;
        w_conf      = 1'b1;
        w_alu_op    = 6'h23;
        w_imm       = w_imm_i;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // Decoded outputs; an illegal instruction collapses to a harmless bubble
  assign bus.alu_op          = w_legal ? w_alu_op : c_alu_illegal;
  assign bus.rd_write_enable = w_legal && w_writes_rd && (w_rd != 5'd0);
  assign bus.res_src         = w_legal && w_res_src;
  assign bus.branch          = w_legal && w_branch;
  assign bus.alu_input_conf  = w_legal && w_conf;
  assign bus.imm             = w_legal ? w_imm : 32'h0000_0000;
  assign bus.rd_write_addr   = w_rd;
  assign bus.pc_out          = bus.pc_in;
  assign bus.next_pc_out     = bus.next_pc_in;

  // Register file; entry 0 is never written so it reads back as zero
  logic [31:0] r_regs [32];

  // Writeback commit on the rising edge, async clear of every register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (bus.reg_write_enable && (bus.reg_write_addr != 5'd0)) begin
      r_regs[bus.reg_write_addr] <= bus.reg_write_data;
    end
  end

  logic w_wb_active;
  assign w_wb_active = bus.reg_write_enable && (bus.reg_write_addr != 5'd0);

  // Source reads with writeback bypass so the write lands in the same cycle
  always_comb begin
    bus.rs1_data = r_regs[w_rs1];
    bus.rs2_data = r_regs[w_rs2];
    if (w_wb_active && (bus.reg_write_addr == w_rs1)) bus.rs1_data = bus.reg_write_data;
    if (w_wb_active && (bus.reg_write_addr == w_rs2)) bus.rs2_data = bus.reg_write_data;
    if (w_rs1 == 5'd0) bus.rs1_data = '0;
    if (w_rs2 == 5'd0) bus.rs2_data = '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_decode
// Description : Self-checking bench for instr_decode: directed instructions
//               and register-file traffic, with a reference model compared
//               every cycle plus literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_decode;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic run_cmp = 1'b0;
  int   checks = 0;
  int   errors = 0;

  instr_decode_if bus ();

  instr_decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  alu;
    logic        we;
    logic        res;
    logic        br;
    logic        conf;
    logic [31:0] imm;
  } exp_t;

  // Reference register file
  logic [31:0] m_regs [32];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
    end else if (bus.reg_write_enable && bus.reg_write_addr != 0) begin
      m_regs[bus.reg_write_addr] <= bus.reg_write_data;
    end
  end

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (bus.reg_write_enable && bus.reg_write_addr == a) return bus.reg_write_data;
    return m_regs[a];
  endfunction

  function automatic int rr(input int f3, input bit alt);
    int tab [8];
    int r;
    tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    r = tab[f3];
    if (alt && f3 == 0) r = 1;
    if (alt && f3 == 5) r = 7;
    return r;
  endfunction

  // Decode rules expressed as arithmetic on the instruction word
  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    int   f3, f7, op, sx, alu;
    bit   legal;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    op = int'(ins[6:0]);
    sx = ins;
    imm_i = 32'(sx >>> 20);
    imm_s = 32'(((sx >>> 25) * 32) + int'(ins[11:7]));
    imm_b = 32'(((sx >>> 31) * 4096) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
    imm_u = ins & 32'hFFFF_F000;
    imm_j = 32'(((sx >>> 31) * 1048576) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2);
    e = '{alu: 6'h3F, we: 0, res: 0, br: 0, conf: 0, imm: 0};
    legal = 0;
    alu = 63;
    case (op)
      'h33: begin
        legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        alu = rr(f3, f7 == 32); e.we = 1;
      end
      'h13: begin
        legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1;
        alu = rr(f3, f3 == 5 && f7 == 32); e.we = 1; e.conf = 1; e.imm = imm_i;
      end
      'h03: begin
        legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        alu = 'h28 + ((f3 >= 4) ? f3 - 1 : f3);
        e.we = 1; e.res = 1; e.conf = 1; e.imm = imm_i;
      end
      'h23: begin
        legal = (f3 < 3); alu = 'h30 + f3; e.conf = 1; e.imm = imm_s;
      end
      'h63: begin
        legal = (f3 != 2 && f3 != 3);
        alu = 'h10 + ((f3 < 2) ? f3 : f3 - 2); e.br = 1; e.imm = imm_b;
      end
      'h37: begin legal = 1; alu = 'h20; e.we = 1; e.conf = 1; e.imm = imm_u; end
      'h17: begin legal = 1; alu = 'h21; e.we = 1; e.conf = 1; e.imm = imm_u; end
      'h6F: begin legal = 1; alu = 'h22; e.we = 1; e.br = 1; e.conf = 1; e.imm = imm_j; end
      'h67: begin legal = (f3 == 0); alu = 'h23; e.we = 1; e.br = 1; e.conf = 1; e.imm = imm_i; end
      default: legal = 0;
    endcase
    if (!legal) begin
      e = '{alu: 6'h3F, we: 0, res: 0, br: 0, conf: 0, imm: 0};
    end else begin
      e.alu = 6'(alu);
      if (ins[11:7] == 0) e.we = 0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (run_cmp) begin
      exp_t e;
      e = model(bus.instr);
      chk("m_alu_op",  32'(bus.alu_op), 32'(e.alu));
      chk("m_rd_we",   32'(bus.rd_write_enable), 32'(e.we));
      chk("m_rd_addr", 32'(bus.rd_write_addr), 32'(bus.instr[11:7]));
      chk("m_res_src", 32'(bus.res_src), 32'(e.res));
      chk("m_branch",  32'(bus.branch), 32'(e.br));
      chk("m_conf",    32'(bus.alu_input_conf), 32'(e.conf));
      chk("m_imm",     bus.imm, e.imm);
      chk("m_rs1",     bus.rs1_data, m_read(bus.instr[19:15]));
      chk("m_rs2",     bus.rs2_data, m_read(bus.instr[24:20]));
      chk("m_pc",      bus.pc_out, bus.pc_in);
      chk("m_npc",     bus.next_pc_out, bus.next_pc_in);
    end
  end

  // Apply a new instruction/writeback set shortly after a rising edge
  task automatic drive(input logic [31:0] ins, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    @(posedge clk);
    #1;
    bus.instr            = ins;
    bus.pc_in            = bus.pc_in + 32'd4;
    bus.next_pc_in       = bus.pc_in + 32'd4;
    bus.reg_write_enable = we;
    bus.reg_write_addr   = wa;
    bus.reg_write_data   = wd;
    #2;
  endtask

  task automatic pin_addi(input logic [31:0] ins, input logic [31:0] imm_exp);
    drive(ins, 1'b0, 5'd0, 32'h0);
    chk("addi_alu_op", 32'(bus.alu_op), 32'h00);
    chk("addi_rd_we",  32'(bus.rd_write_enable), 32'd1);
    chk("addi_rd",     32'(bus.rd_write_addr), 32'd1);
    chk("addi_res",    32'(bus.res_src), 32'd0);
    chk("addi_branch", 32'(bus.branch), 32'd0);
    chk("addi_conf",   32'(bus.alu_input_conf), 32'd1);
    chk("addi_imm",    bus.imm, imm_exp);
  endtask

  logic [31:0] extra [14];

  initial begin
    bus.instr            = 32'h0;
    bus.pc_in            = 32'h0000_1000;
    bus.next_pc_in       = 32'h0000_1004;
    bus.reg_write_enable = 1'b0;
    bus.reg_write_addr   = 5'd0;
    bus.reg_write_data   = 32'h0;
    #1 rst_n = 1'b0;
    #12 rst_n = 1'b1;
    run_cmp = 1'b1;

    // Reset state and the addi sequence
    pin_addi(32'h3E808093, 32'd1000);
    chk("reset_rs1", bus.rs1_data, 32'h0);
    pin_addi(32'h4B008093, 32'd1200);
    pin_addi(32'h57808093, 32'd1400);
    pin_addi(32'h64008093, 32'd1600);
    pin_addi(32'h70808093, 32'd1800);

    // Bypass in the write cycle, then the stored value
    drive(32'h3E808093, 1'b1, 5'd1, 32'hDEADBEEF);
    chk("bypass_rs1", bus.rs1_data, 32'hDEADBEEF);
    drive(32'h3E808093, 1'b0, 5'd0, 32'h0);
    chk("stored_rs1", bus.rs1_data, 32'hDEADBEEF);

    // x0 stays zero through a write attempt
    drive(32'h00000093, 1'b1, 5'd0, 32'd5);
    chk("x0_bypass", bus.rs1_data, 32'h0);
    drive(32'h00000093, 1'b0, 5'd0, 32'h0);
    chk("x0_stored", bus.rs1_data, 32'h0);

    // Second operand via x2, then async reset clears without a clock edge
    drive(32'hFE208EE3, 1'b1, 5'd2, 32'h12345678);
    chk("beq_alu_op", 32'(bus.alu_op), 32'h10);
    chk("beq_branch", 32'(bus.branch), 32'd1);
    chk("beq_rd_we",  32'(bus.rd_write_enable), 32'd0);
    chk("beq_conf",   32'(bus.alu_input_conf), 32'd0);
    chk("beq_imm",    bus.imm, 32'hFFFFFFFC);
    chk("beq_rs2",    bus.rs2_data, 32'h12345678);
    drive(32'h3E808093, 1'b0, 5'd0, 32'h0);
    chk("pre_rst_rs1", bus.rs1_data, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rs1", bus.rs1_data, 32'h0);
    rst_n = 1'b1;

    drive(32'h00812283, 1'b0, 5'd0, 32'h0);
    chk("lw_alu_op", 32'(bus.alu_op), 32'h2A);
    chk("lw_res",    32'(bus.res_src), 32'd1);
    chk("lw_rd",     32'(bus.rd_write_addr), 32'd5);
    chk("lw_imm",    bus.imm, 32'd8);
    drive(32'hFFF00093, 1'b0, 5'd0, 32'h0);
    chk("neg_imm", bus.imm, 32'hFFFFFFFF);
    drive(32'hFFFFFFFF, 1'b0, 5'd0, 32'h0);
    chk("ill_alu_op", 32'(bus.alu_op), 32'h3F);
    chk("ill_rd_we",  32'(bus.rd_write_enable), 32'd0);
    chk("ill_imm",    bus.imm, 32'h0);

    drive(32'h123450B7, 1'b0, 5'd0, 32'h0);
    chk("lui_imm", bus.imm, 32'h12345000);
    drive(32'h008000EF, 1'b0, 5'd0, 32'h0);
    chk("jal_imm", bus.imm, 32'd8);
    chk("jal_alu_op", 32'(bus.alu_op), 32'h22);
    drive(32'h4020D1B3, 1'b0, 5'd0, 32'h0);
    chk("sra_alu_op", 32'(bus.alu_op), 32'h07);
    drive(32'h00112423, 1'b0, 5'd0, 32'h0);
    chk("sw_imm", bus.imm, 32'd8);
    chk("sw_alu_op", 32'(bus.alu_op), 32'h32);

    // Broader coverage, checked by the per-cycle model
    extra = '{32'h002081B3, 32'h402081B3, 32'h00001097, 32'h000080E7,
              32'h4010D093, 32'h021081B3, 32'h00100013, 32'h40000093,
              32'h0000C283, 32'h00209463, 32'hFE20FEE3, 32'h00112223,
              32'h00003023, 32'h0000A303};
    drive(32'h00000013, 1'b1, 5'd1, 32'hCAFEF00D);
    for (int k = 0; k < 14; k++) begin
      drive(extra[k], (k % 3) == 0, 5'(k + 1), 32'hA5A50000 + 32'(k));
    end
    drive(32'h00000013, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    run_cmp = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
